// File: rtl/btn_debounce_pio.sv
// btn_debounce_pio: per-channel synchroniser, tick-based debouncer and edge flags on the 8-bit IO bus.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to add per-channel long-press detection and the LPF register.
module btn_debounce_pio #(
  parameter int                           CHANNELS          = 6,
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PIN_ADDR          = 'h23,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] IFR_ADDR          = 'h24,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] IMSK_ADDR         = 'h25,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] EDGE_ADDR         = 'h26,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] LPF_ADDR          = 'h27,
  parameter int                           SYNC_STAGES       = 2,
  parameter int                           PRESCALE          = 16000,
  parameter int                           DEB_TICKS         = 5,
  parameter logic [7:0]                   INVERSE_MASK      = 8'h00,
  parameter int                           LONG_TICKS        = 1000
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  input  logic [CHANNELS-1:0]          io_i,
  output logic [CHANNELS-1:0]          pressed_o,
  output logic                         intr_o,
  input  logic                         int_ack_i
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CHANNELS-1:0] REL_LVL = INVERSE_MASK[CHANNELS-1:0];

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0]       r_presc;
  logic [DW-1:0]       r_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_stable;
  logic [CHANNELS-1:0] r_stable_q;
  logic [CHANNELS-1:0] r_ifr;
  logic [CHANNELS-1:0] r_imsk;
  logic [CHANNELS-1:0] r_edge;
  logic                r_intr;

  logic                w_tick;
  logic [CHANNELS-1:0] w_p;
  logic [CHANNELS-1:0] w_ifr_set;
  logic [CHANNELS-1:0] w_ifr_clr;
  logic [CHANNELS-1:0] w_flags;
  logic                w_sel_pin;
  logic                w_sel_ifr;
  logic                w_sel_imsk;
  logic                w_sel_edge;
  logic [7:0]          w_rd;
  logic                w_unused_bus;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Chain resets to the released level so reset release produces no edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= REL_LVL;
    end else begin
      r_sync[0] <= io_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_p = r_sync[SYNC_STAGES-1] ^ REL_LVL;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stable   <= '0;
      r_stable_q <= '0;
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
    end else begin
      r_stable_q <= r_stable;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_p[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == DW'(DEB_TICKS - 1)) begin
            r_stable[i] <= w_p[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + DW'(1);
          end
        end
      end
    end
  end

  assign pressed_o  = r_stable;
  assign w_sel_pin  = (addr_i == PIN_ADDR);
  assign w_sel_ifr  = (addr_i == IFR_ADDR);
  assign w_sel_imsk = (addr_i == IMSK_ADDR);
  assign w_sel_edge = (addr_i == EDGE_ADDR);

  assign w_ifr_set = (r_stable & ~r_stable_q) | (~r_stable & r_stable_q & r_edge);
  assign w_ifr_clr = ((wr_i & w_sel_ifr) ? bus_i[CHANNELS-1:0] : '0) |
                     (int_ack_i ? r_imsk : '0);

  // Set is OR-ed in after the clear, so a coincident edge always survives.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ifr  <= '0;
      r_imsk <= '0;
      r_edge <= '0;
    end else begin
      r_ifr <= (r_ifr & ~w_ifr_clr) | w_ifr_set;
      if (wr_i && w_sel_imsk) r_imsk <= bus_i[CHANNELS-1:0];
      if (wr_i && w_sel_edge) r_edge <= bus_i[CHANNELS-1:0];
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic [HW-1:0]       r_hold [CHANNELS];
  logic [CHANNELS-1:0] r_lpf;
  logic [CHANNELS-1:0] w_lpf_set;
  logic [CHANNELS-1:0] w_lpf_clr;
  logic                w_sel_lpf;

  assign w_sel_lpf = (addr_i == LPF_ADDR);
  assign w_lpf_clr = ((wr_i & w_sel_lpf) ? bus_i[CHANNELS-1:0] : '0) |
                     (int_ack_i ? r_imsk : '0);

  always_comb begin
    w_lpf_set = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_lpf_set[i] = w_tick & r_stable[i] & (r_hold[i] == HW'(LONG_TICKS - 1));
  end

  // Hold counter saturates at LONG_TICKS, so the flag fires once per press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lpf <= '0;
      for (int i = 0; i < CHANNELS; i++) r_hold[i] <= '0;
    end else begin
      r_lpf <= (r_lpf & ~w_lpf_clr) | w_lpf_set;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!r_stable[i]) r_hold[i] <= '0;
        else if (w_tick && (r_hold[i] != HW'(LONG_TICKS))) r_hold[i] <= r_hold[i] + HW'(1);
      end
    end
  end

  assign w_flags = r_ifr | r_lpf;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (LONG_TICKS > 0) ^ (addr_i == LPF_ADDR);
  assign w_flags      = r_ifr;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_intr <= 1'b0;
    else          r_intr <= |(w_flags & r_imsk);
  end

  assign intr_o = r_intr;

  always_comb begin
    w_rd = '0;
    if (rd_i) begin
      if (w_sel_pin)       w_rd[CHANNELS-1:0] = r_stable;
      else if (w_sel_ifr)  w_rd[CHANNELS-1:0] = r_ifr;
      else if (w_sel_imsk) w_rd[CHANNELS-1:0] = r_imsk;
      else if (w_sel_edge) w_rd[CHANNELS-1:0] = r_edge;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      else if (w_sel_lpf)  w_rd[CHANNELS-1:0] = r_lpf;
`endif
    end
  end

  assign bus_o        = w_rd;
  assign w_unused_bus = ^bus_i;

endmodule
